fetch_stage_q: RTL and testbench
================================

Name: fetch_stage_q

Overview:
- Parametrised instruction-fetch stage. Holds the PC and issues word addresses to instruction memory, which may insert wait states.
- Buffers fetched {PC, instruction, PC+4} in a small in-order queue, which replaces the single IF/ID register. Presents the queue head to decode with a valid/ready handshake.
- Handles branch/jump redirect with a full flush, plus a decode-side stall.
- Sits between the PC-select logic of EX/MEM and the decode stage.

Parameters:
- XLEN, 32, data/address width in bits; must be ≥ 8.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FQ_DEPTH, 2, fetch queue entries; power of 2 and ≥ 2.
- NOP_INSTR, 32'h0000_0000, value driven on id_instr while queue empty or in reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  out  XLEN  fetch address (current PC, low 2 bits always 0).
- imem_req  out  1  fetch request; high when queue not full and rst low.
- imem_rdata  in  32  instruction word for imem_addr.
- imem_valid  in  1  imem_rdata valid this cycle; may stay low for wait states.
- redirect  in  1  taken branch/jump; flush and refetch from redirect_pc.
- redirect_pc  in  XLEN  target address; bits [1:0] ignored (forced 0).
- id_ready  in  1  decode accepts head entry this cycle (low = stall).
- id_valid  out  1  head entry valid.
- id_instr  out  32  head instruction; NOP_INSTR when id_valid=0.
- id_pc  out  XLEN  head PC; 0 when id_valid=0.
- id_pc_plus4  out  XLEN  head PC+4; 0 when id_valid=0.
- fq_count  out  $clog2(FQ_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset: one clock with rst high sets pc=RESET_PC, clears queue pointers and count, id_valid=0, id_instr=NOP_INSTR, id_pc=id_pc_plus4=0, imem_req=0.
  - rst high mid-operation discards all queued and in-flight entries immediately.
- PC/request:
  - imem_addr = {pc[XLEN-1:2], 2'b00}, combinational from the pc register.
  - imem_req = !rst && (fq_count != FQ_DEPTH).
- Push: when imem_req && imem_valid && !redirect, write {pc, imem_rdata, pc+4} at the tail and set pc <= pc+4. pc+4 wraps modulo 2^XLEN.
  - imem_valid while the queue is full is ignored; pc holds.
  - There is no combinational path from id_ready to imem_req; a pop does not free a slot for the same-cycle push.
- Pop: when id_valid && id_ready, advance the head.
  - Outputs are driven combinationally from the head storage. Latency from an accepted imem_valid to id_valid is 1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - With FQ_DEPTH ≥ 2 and zero-wait memory, steady state sustains 1 instr/cycle.
- Redirect (priority: rst > redirect > push/pop):
  - Queue cleared (count=0, pointers equal).
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - The same-cycle imem response is dropped; a same-cycle pop is irrelevant.
  - Next cycle id_valid=0; the first target instruction appears on id_* one cycle after imem_valid for the target.
- Stall: id_ready low holds the head stable (id_instr, id_pc, id_pc_plus4 unchanged).
  - Fetching continues until the queue is full, then imem_req drops.
- Empty: id_valid=0 and outputs at the null values above; id_ready is don't-care.
- Wait states: while imem_valid is low, pc and queue hold; imem_addr remains stable until the accepting cycle.
- Pointer wrap: head and tail pointers are $clog2(FQ_DEPTH) bits and wrap naturally. Full/empty is derived from fq_count, never from pointer equality.
- No X propagation: queue storage need not be reset, but outputs are muxed to the null values when id_valid=0.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_entry_t struct {pc, instr, pc_plus4};
  - NOP constant;
  - helper function for word-aligning an address.
- One sub-module: fetch_queue, a synchronous-reset FIFO of fetch_entry_t with push/pop/flush and a count output.
- PC register, request logic and the redirect mux stay in fetch_stage_q.

Test Plan:
- Reset with RESET_PC=32'h100, zero-wait memory, id_ready=1 → imem_addr 0x100, 0x104, 0x108 on consecutive cycles; id_pc trails by 1 cycle; id_pc_plus4 = id_pc+4.
- Hold id_ready=0 for 5 cycles from steady state → fq_count reaches 2, imem_req=0, id_pc frozen at 0x104; on release, 0x104, 0x108, 0x10C issue with no duplication or loss.
- imem_valid low for 3 cycles at 0x108 → imem_addr held at 0x108, no push; the entry appears 1 cycle after imem_valid rises.
- redirect=1, redirect_pc=32'h203 with 2 entries queued → next cycle fq_count=0, id_valid=0, imem_addr=0x200; the next delivered id_pc is 0x200.
- rst asserted mid-stream with a full queue → next cycle id_valid=0, id_instr=NOP_INSTR, imem_addr=RESET_PC, fq_count=0.
- PC at 32'hFFFF_FFFC, fetch accepted → id_pc_plus4=0 and next imem_addr=0 (wrap).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [FETCH_XLEN-1:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [FETCH_XLEN-1:0] word_align(input logic [FETCH_XLEN-1:0] addr);
    return {addr[FETCH_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_q_if.sv
// Instruction-memory and decode-side signals of the fetch stage.
interface fetch_stage_q_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FQ_DEPTH = 2
) ();
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic [31:0]     imem_rdata;
  logic            imem_valid;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic [CW-1:0]   fq_count;

  modport master (
    output imem_addr, imem_req,
    input  imem_rdata, imem_valid,
    input  redirect, redirect_pc, id_ready,
    output id_valid, id_instr, id_pc, id_pc_plus4, fq_count
  );

  modport slave (
    input  imem_addr, imem_req,
    output imem_rdata, imem_valid,
    output redirect, redirect_pc, id_ready,
    input  id_valid, id_instr, id_pc, id_pc_plus4, fq_count
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order FIFO of fetch entries; full/empty come from the count, not pointers.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  entry_t        i_data,
  input  logic          i_pop,
  output entry_t        o_head,
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  entry_t        r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage is deliberately unreset; consumers mask it when the queue is empty.
  always_ff @(posedge clk) begin
    if (i_push && !rst && !i_flush) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage_q.sv
// Fetch stage: PC register, imem request, redirect handling and the fetch queue.
module fetch_stage_q
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     FQ_DEPTH  = 2,
  parameter logic [31:0]     NOP_INSTR = NOP
) (
  input logic             clk,
  input logic             rst,
  fetch_stage_q_if.master fs
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_plus4;
  } fq_entry_t;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_addr_plus4;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_req;
  logic            w_push;
  logic            w_valid;
  logic            w_pop;
  fq_entry_t       w_wr;
  fq_entry_t       w_head;

  assign w_addr       = r_pc & ~XLEN'(3);
  assign w_addr_plus4 = w_addr + XLEN'(4);
  assign w_full       = (w_count == CW'(FQ_DEPTH));
  assign w_req        = !rst && !w_full;
  assign w_push       = w_req && fs.imem_valid && !fs.redirect;
  assign w_valid      = !rst && (w_count != '0);
  assign w_pop        = w_valid && fs.id_ready;

  always_comb begin
    w_wr          = '0;
    w_wr.pc       = w_addr;
    w_wr.instr    = fs.imem_rdata;
    w_wr.pc_plus4 = w_addr_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (fs.redirect) begin
      r_pc <= fs.redirect_pc & ~XLEN'(3);
    end else if (w_push) begin
      r_pc <= w_addr_plus4;
    end
  end

  fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (fq_entry_t)
  ) u_fq (
    .clk     (clk),
    .rst     (rst),
    .i_flush (fs.redirect),
    .i_push  (w_push),
    .i_data  (w_wr),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign fs.imem_addr   = w_addr;
  assign fs.imem_req    = w_req;
  assign fs.fq_count    = w_count;
  assign fs.id_valid    = w_valid;
  assign fs.id_instr    = w_valid ? w_head.instr    : NOP_INSTR;
  assign fs.id_pc       = w_valid ? w_head.pc       : '0;
  assign fs.id_pc_plus4 = w_valid ? w_head.pc_plus4 : '0;

endmodule

// File: tb/tb_fetch_stage_q.sv
// Directed bench for fetch_stage_q with a queue-based scoreboard of expected entries.
module tb_fetch_stage_q;
  import fetch_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] NOPI  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_q_if #(.XLEN(XLEN), .FQ_DEPTH(DEPTH)) bus ();

  fetch_stage_q #(
    .XLEN      (XLEN),
    .RESET_PC  (RPC),
    .FQ_DEPTH  (DEPTH),
    .NOP_INSTR (NOPI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fs  (bus.master)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  assign bus.imem_rdata = mem_f(bus.imem_addr);

  fetch_entry_t sb[$];
  logic [31:0]  mpc = RPC;
  int           errors = 0;
  int           checks = 0;
  bit           chk_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current outputs against the model, then advance the model over one edge.
  task automatic cyc();
    fetch_entry_t e;
    int unsigned  n;
    bit           vexp;
    bit           pop;
    bit           push;
    #1;
    n    = sb.size();
    vexp = !rst && (n != 0);
    if (chk_en) begin
      check("imem_req", 64'(bus.imem_req), 64'(!rst && (n != DEPTH)));
      if (!rst) check("imem_addr", 64'(bus.imem_addr), 64'(mpc));
      check("fq_count", 64'(bus.fq_count), 64'(n));
      check("id_valid", 64'(bus.id_valid), 64'(vexp));
      if (vexp) begin
        check("id_instr", 64'(bus.id_instr), 64'(sb[0].instr));
        check("id_pc", 64'(bus.id_pc), 64'(sb[0].pc));
        check("id_pc_plus4", 64'(bus.id_pc_plus4), 64'(sb[0].pc_plus4));
      end else begin
        check("null_instr", 64'(bus.id_instr), 64'(NOPI));
        check("null_pc", 64'(bus.id_pc), 64'(0));
        check("null_pc_plus4", 64'(bus.id_pc_plus4), 64'(0));
      end
    end
    pop  = vexp && bus.id_ready;
    push = !rst && !bus.redirect && bus.imem_valid && (n != DEPTH);
    if (rst) begin
      sb.delete();
      mpc = RPC;
    end else if (bus.redirect) begin
      sb.delete();
      mpc = word_align(bus.redirect_pc);
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        e.pc       = mpc;
        e.instr    = mem_f(mpc);
        e.pc_plus4 = mpc + 32'd4;
        sb.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.imem_valid  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready    = 1'b1;
    rst             = 1'b1;
    @(negedge clk);
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    check("reset_addr", 64'(bus.imem_addr), 64'(32'h100));

    // Zero-wait streaming.
    cyc();
    check("first_id_pc", 64'(bus.id_pc), 64'(32'h100));
    check("first_next_addr", 64'(bus.imem_addr), 64'(32'h104));
    cyc();
    check("stream_id_pc", 64'(bus.id_pc), 64'(32'h104));

    // Decode stall fills the queue and drops the request.
    bus.id_ready = 1'b0;
    repeat (5) cyc();
    check("stall_count", 64'(bus.fq_count), 64'(2));
    check("stall_req", 64'(bus.imem_req), 64'(0));
    check("stall_frozen_pc", 64'(bus.id_pc), 64'(32'h104));
    bus.id_ready = 1'b1;
    cyc();
    check("release_pc", 64'(bus.id_pc), 64'(32'h108));
    repeat (3) cyc();

    // Memory wait states.
    bus.imem_valid = 1'b0;
    repeat (3) cyc();
    check("wait_drained", 64'(bus.id_valid), 64'(0));
    bus.imem_valid = 1'b1;
    repeat (3) cyc();

    // Redirect with two entries queued and a same-cycle response.
    bus.id_ready = 1'b0;
    repeat (2) cyc();
    check("pre_redirect_count", 64'(bus.fq_count), 64'(2));
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    cyc();
    bus.redirect = 1'b0;
    check("redir_count", 64'(bus.fq_count), 64'(0));
    check("redir_valid", 64'(bus.id_valid), 64'(0));
    check("redir_addr", 64'(bus.imem_addr), 64'(32'h200));
    bus.id_ready = 1'b1;
    cyc();
    check("redir_target_pc", 64'(bus.id_pc), 64'(32'h200));
    repeat (2) cyc();

    // Reset mid-stream with a full queue.
    bus.id_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_valid", 64'(bus.id_valid), 64'(0));
    check("rst_instr", 64'(bus.id_instr), 64'(NOPI));
    check("rst_addr", 64'(bus.imem_addr), 64'(RPC));
    check("rst_count", 64'(bus.fq_count), 64'(0));
    bus.id_ready = 1'b1;
    repeat (2) cyc();

    // PC wrap at the top of the address space.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect = 1'b0;
    cyc();
    check("wrap_pc", 64'(bus.id_pc), 64'(32'hFFFF_FFFC));
    check("wrap_pc_plus4", 64'(bus.id_pc_plus4), 64'(0));
    check("wrap_addr", 64'(bus.imem_addr), 64'(0));
    repeat (2) cyc();

    // Mixed wait states and stalls.
    for (int i = 0; i < 40; i++) begin
      bus.imem_valid = ($urandom_range(0, 3) != 0);
      bus.id_ready   = ($urandom_range(0, 2) != 0);
      cyc();
    end
    bus.imem_valid = 1'b0;
    bus.id_ready   = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
